// File: rtl/calc_pkg.sv
// Shared constants for the calculator display consumer:
// producer status codes, segment patterns and digit count.
package calc_pkg;
  localparam logic [1:0] ST_ERRO  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_PRINT = 2'b11;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_R     = 8'hAF;

  localparam int NDIG = 8;
endpackage

// File: rtl/calc_display_ctrl_if.sv
// Display-digit stream from the calculator core and the
// multiplexed 7-segment outputs of the display controller.
interface calc_display_ctrl_if;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic [7:0] an;
  logic [7:0] seg;
  logic       commit;

  modport master (
    output status, data, pos,
    input  an, seg, commit
  );

  modport slave (
    input  status, data, pos,
    output an, seg, commit
  );
endinterface

// File: rtl/calc_display_ctrl_seg7_decoder.sv
// BCD digit to active-low {dp,g,f,e,d,c,b,a} segments;
// codes 10..15 light nothing.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [7:0] o_seg
);
  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_digit)
      4'd0:    o_seg = 8'hC0;
      4'd1:    o_seg = 8'hF9;
      4'd2:    o_seg = 8'hA4;
      4'd3:    o_seg = 8'hB0;
      4'd4:    o_seg = 8'h99;
      4'd5:    o_seg = 8'h92;
      4'd6:    o_seg = 8'h82;
      4'd7:    o_seg = 8'hF8;
      4'd8:    o_seg = 8'h80;
      4'd9:    o_seg = 8'h90;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/calc_display_ctrl.sv
// Captures 8-digit print bursts into a shadow buffer, commits
// them at end of frame and scans them onto a 7-segment display.
module calc_display_ctrl
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  calc_display_ctrl_if.slave  bus
);
  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0]        r_div;
  logic [2:0]           r_idx;
  logic [1:0]           r_prev;
  logic [NDIG-1:0][3:0] r_shadow;
  logic [NDIG-1:0][3:0] r_active;
  logic [7:0]           r_an;
  logic [7:0]           r_seg;
  logic                 r_commit;

  logic       w_beat;
  logic       w_commit;
  logic       w_abort;
  logic [2:0] w_wr_idx;
  logic [2:0] w_msd;
  logic [3:0] w_digit;
  logic [7:0] w_dec;
  logic [7:0] w_seg_nxt;

  assign w_beat   = (bus.status == ST_PRINT)
                  && (bus.pos >= 4'd1)
                  && (bus.pos <= 4'd8);
  assign w_commit = (r_prev == ST_PRINT)
                  && (bus.status == ST_READY);
  assign w_abort  = (r_prev == ST_PRINT)
                  && ((bus.status == ST_ERRO)
                  ||  (bus.status == ST_BUSY));
  assign w_wr_idx = 3'(bus.pos - 4'd1);

  // Digit 0 is never blanked, so msd bottoms out at 0.
  always_comb begin
    w_msd = 3'd0;
    for (int i = 1; i < NDIG; i++) begin
      if (r_active[i] != 4'd0) w_msd = 3'(i);
    end
  end

  assign w_digit = r_active[r_idx];

  seg7_decoder u_dec (
    .i_digit (w_digit),
    .o_seg   (w_dec)
  );

  always_comb begin
    w_seg_nxt = w_dec;
    if (bus.status == ST_ERRO) begin
      if (r_idx == 3'd2)     w_seg_nxt = SEG_E;
      else if (r_idx < 3'd2) w_seg_nxt = SEG_R;
      else                   w_seg_nxt = SEG_BLANK;
    end else if (BLANK_LZ && (r_idx > w_msd)) begin
      w_seg_nxt = SEG_BLANK;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev   <= ST_READY;
      r_shadow <= '0;
      r_active <= '0;
      r_commit <= 1'b0;
    end else begin
      r_prev   <= bus.status;
      r_commit <= w_commit;
      if (w_beat) r_shadow[w_wr_idx] <= bus.data;
      if (w_commit) begin
        r_active <= r_shadow;
        r_shadow <= '0;
      end else if (w_abort) begin
        r_shadow <= '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_idx <= 3'd0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_an  <= 8'hFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(8'd1 << r_idx);
      r_seg <= w_seg_nxt;
    end
  end

  assign bus.an     = r_an;
  assign bus.seg    = r_seg;
  assign bus.commit = r_commit;
endmodule
